uxy_wiring_table: RTL and testbench

Parametrised, run-time-programmable wiring table for universal gates. Each entry, indexed by a function code, holds one wiring selector per gate pin. The block serves per-pin lookups, or whole-gate bursts, over a valid/ready handshake. It generalises the fixed 2-input single-lookup combinational table. It sits between the configuration loader, which writes entries, and the gate-mapping sequencer, which consumes wiring beats.

---
 rtl/unigate_pkg.sv | 20 ++
 rtl/uxy_wiring_table_if.sv | 53 +++++
 rtl/uxy_wiring_store.sv | 41 ++++
 rtl/uxy_wiring_table.sv | 137 +++++++++++++
 tb/tb_uxy_wiring_table.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/unigate_pkg.sv
// Shared definitions for the universal-gate wiring blocks.
//   state_t  : lookup FSM encoding (ST_IDLE, ST_SEND)
//   DEF_*    : default parameter values
//   entry_w  : packed entry width for a given pin count and selector width
package unigate_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  localparam int DEF_FUNC_W = 4;
  localparam int DEF_PIN_W  = 2;
  localparam int DEF_WIRE_W = 3;

  function automatic int entry_w(input int pin_w, input int wire_w);
    return (1 << pin_w) * wire_w;
  endfunction

endpackage

// File: rtl/uxy_wiring_table_if.sv
// Bus bundle between the wiring table and its neighbours.
//   write port   : wr_en, wr_func, wr_data (from the configuration loader)
//   request      : req_valid/req_ready, req_func, req_pin, req_burst
//   response     : rsp_valid/rsp_ready, rsp_wiring, rsp_pin, rsp_last, rsp_miss
//   status       : busy
// slave = the wiring table, master = the loader/sequencer side.
interface uxy_wiring_table_if
  import unigate_pkg::*;
#(
  parameter int FUNC_W  = DEF_FUNC_W,
  parameter int PIN_W   = DEF_PIN_W,
  parameter int WIRE_W  = DEF_WIRE_W,
  parameter int ENTRY_W = entry_w(PIN_W, WIRE_W)
) ();

  logic               wr_en;
  logic [FUNC_W-1:0]  wr_func;
  logic [ENTRY_W-1:0] wr_data;

  logic               req_valid;
  logic               req_ready;
  logic [FUNC_W-1:0]  req_func;
  logic [PIN_W-1:0]   req_pin;
  logic               req_burst;

  logic               rsp_valid;
  logic               rsp_ready;
  logic [WIRE_W-1:0]  rsp_wiring;
  logic [PIN_W-1:0]   rsp_pin;
  logic               rsp_last;
  logic               rsp_miss;

  logic               busy;

  modport slave (
    input  wr_en, wr_func, wr_data,
    input  req_valid, req_func, req_pin, req_burst,
    output req_ready,
    output rsp_valid, rsp_wiring, rsp_pin, rsp_last, rsp_miss,
    input  rsp_ready,
    output busy
  );

  modport master (
    output wr_en, wr_func, wr_data,
    output req_valid, req_func, req_pin, req_burst,
    input  req_ready,
    input  rsp_valid, rsp_wiring, rsp_pin, rsp_last, rsp_miss,
    output rsp_ready,
    input  busy
  );

endinterface

// File: rtl/uxy_wiring_store.sv
// Wiring entry storage: ENTRIES x ENTRY_W registers plus a written-since-reset
// bit per entry.
//   clk, rst_n        : clock, async active-low reset (clears data and valid)
//   wr_en_i/func/data : write port, always accepted
//   rd_func_i         : asynchronous read address
//   rd_data_o/valid_o : entry contents and its valid bit
module uxy_wiring_store #(
  parameter int FUNC_W  = 4,
  parameter int ENTRY_W = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en_i,
  input  logic [FUNC_W-1:0]  wr_func_i,
  input  logic [ENTRY_W-1:0] wr_data_i,
  input  logic [FUNC_W-1:0]  rd_func_i,
  output logic [ENTRY_W-1:0] rd_data_o,
  output logic               rd_valid_o
);

  localparam int ENTRIES = 1 << FUNC_W;

  logic [ENTRY_W-1:0] data_q [ENTRIES];
  logic [ENTRIES-1:0] valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) data_q[i] <= '0;
      valid_q <= '0;
    end else if (wr_en_i) begin
      data_q[wr_func_i]  <= wr_data_i;
      valid_q[wr_func_i] <= 1'b1;
    end
  end

  // Read is combinational on the current register contents, so a request
  // accepted on the same edge as a write to the same entry sees the old data.
  assign rd_data_o  = data_q[rd_func_i];
  assign rd_valid_o = valid_q[rd_func_i];

endmodule

// File: rtl/uxy_wiring_table.sv
// Run-time-programmable wiring table for universal gates.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of uxy_wiring_table_if (write port, lookup
//                request, response beats, busy)
// A request snapshots the addressed entry, then streams one beat (single) or
// PINS beats starting at req_pin and wrapping (burst).
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | req_ready=1, waiting for a request
// ST_SEND | rsp_valid=1, presenting the current beat until rsp_ready
module uxy_wiring_table
  import unigate_pkg::*;
#(
  parameter int FUNC_W = DEF_FUNC_W,
  parameter int PIN_W  = DEF_PIN_W,
  parameter int WIRE_W = DEF_WIRE_W
) (
  input  logic                clk,
  input  logic                rst_n,
  uxy_wiring_table_if.slave   bus
);

  localparam int ENTRY_W = entry_w(PIN_W, WIRE_W);
  localparam int PINS    = 1 << PIN_W;

  logic [ENTRY_W-1:0] rd_data;
  logic               rd_valid;

  uxy_wiring_store #(
    .FUNC_W  (FUNC_W),
    .ENTRY_W (ENTRY_W)
  ) u_store (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (bus.wr_en),
    .wr_func_i  (bus.wr_func),
    .wr_data_i  (bus.wr_data),
    .rd_func_i  (bus.req_func),
    .rd_data_o  (rd_data),
    .rd_valid_o (rd_valid)
  );

  state_t             state_q,      state_d;
  logic [ENTRY_W-1:0] snap_data_q,  snap_data_d;
  logic               snap_valid_q, snap_valid_d;
  logic [PIN_W-1:0]   cnt_q,        cnt_d;
  logic [WIRE_W-1:0]  wiring_q,     wiring_d;
  logic [PIN_W-1:0]   pin_q,        pin_d;
  logic               last_q,       last_d;
  logic               miss_q,       miss_d;
  logic [PIN_W-1:0]   pin_nx;
  logic [PIN_W-1:0]   cnt_nx;

  // Unwritten entries report wiring 0 regardless of stored data.
  function automatic logic [WIRE_W-1:0] wiring_at(
    input logic [ENTRY_W-1:0] entry,
    input logic               vld,
    input logic [PIN_W-1:0]   pin
  );
    return vld ? entry[WIRE_W*pin +: WIRE_W] : '0;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      snap_data_q  <= '0;
      snap_valid_q <= 1'b0;
      cnt_q        <= '0;
      wiring_q     <= '0;
      pin_q        <= '0;
      last_q       <= 1'b0;
      miss_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      snap_data_q  <= snap_data_d;
      snap_valid_q <= snap_valid_d;
      cnt_q        <= cnt_d;
      wiring_q     <= wiring_d;
      pin_q        <= pin_d;
      last_q       <= last_d;
      miss_q       <= miss_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    snap_data_d  = snap_data_q;
    snap_valid_d = snap_valid_q;
    cnt_d        = cnt_q;
    wiring_d     = wiring_q;
    pin_d        = pin_q;
    last_d       = last_q;
    miss_d       = miss_q;
    pin_nx       = pin_q + 1'b1;
    cnt_nx       = cnt_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          state_d      = ST_SEND;
          snap_data_d  = rd_data;
          snap_valid_d = rd_valid;
          cnt_d        = '0;
          // First beat is loaded straight from the store so it appears on
          // the cycle after accept.
          wiring_d     = wiring_at(rd_data, rd_valid, bus.req_pin);
          pin_d        = bus.req_pin;
          last_d       = !bus.req_burst;
          miss_d       = !rd_valid;
        end
      end
      ST_SEND: begin
        if (bus.rsp_ready) begin
          if (last_q) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d    = cnt_nx;
            pin_d    = pin_nx;
            wiring_d = wiring_at(snap_data_q, snap_valid_q, pin_nx);
            last_d   = (cnt_nx == PIN_W'(PINS - 1));
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.rsp_valid  = (state_q == ST_SEND);
  assign bus.rsp_wiring = wiring_q;
  assign bus.rsp_pin    = pin_q;
  assign bus.rsp_last   = last_q;
  assign bus.rsp_miss   = miss_q;

endmodule

// File: tb/tb_uxy_wiring_table.sv
module tb_uxy_wiring_table;

  localparam int FUNC_W  = 4;
  localparam int PIN_W   = 2;
  localparam int WIRE_W  = 3;
  localparam int PINS    = 4;
  localparam int ENTRIES = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uxy_wiring_table_if bus ();

  uxy_wiring_table dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: entry contents and written flags, indexed by function.
  logic [11:0] m_data [ENTRIES];
  bit          m_valid [ENTRIES];

  // Expected beat: {wiring[2:0], pin[1:0], last, miss}
  logic [6:0] sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < ENTRIES; i++) begin
      m_data[i]  = '0;
      m_valid[i] = 0;
    end
  endfunction

  function automatic void push_expected(input int f, input int pin, input bit burst);
    int n = burst ? PINS : 1;
    for (int k = 0; k < n; k++) begin
      int p = (pin + k) % PINS;
      int w = m_valid[f] ? ((m_data[f] >> (3 * p)) & 7) : 0;
      sb.push_back({3'(w), 2'(p), (k == n - 1), !m_valid[f]});
    end
  endfunction

  // Monitor: pops on accepted beats, checks stability while stalled.
  initial begin
    logic [6:0] got;
    forever begin
      @(negedge clk);
      if (rst_n && bus.rsp_valid) begin
        got = {bus.rsp_wiring, bus.rsp_pin, bus.rsp_last, bus.rsp_miss};
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat actual=%0h required=none at %0t", got, $time);
        end else if (bus.rsp_ready) begin
          chk("beat", 32'(got), 32'(sb.pop_front()));
        end else begin
          chk("held_beat", 32'(got), 32'(sb[0]));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int f, input logic [11:0] d);
    bus.wr_en = 1'b1; bus.wr_func = 4'(f); bus.wr_data = d;
    step();
    bus.wr_en = 1'b0;
    m_data[f] = d; m_valid[f] = 1;
  endtask

  task automatic issue(input int f, input int pin, input bit burst,
                       input bit wr, input int wf, input logic [11:0] wd);
    int n = 0;
    while (!bus.req_ready && n < 50) begin step(); n++; end
    chk("req_ready_wait", 32'(n < 50), 32'd1);
    bus.req_valid = 1'b1; bus.req_func = 4'(f);
    bus.req_pin = 2'(pin); bus.req_burst = burst;
    if (wr) begin bus.wr_en = 1'b1; bus.wr_func = 4'(wf); bus.wr_data = wd; end
    push_expected(f, pin, burst);  // old contents: read-before-write
    step();
    bus.req_valid = 1'b0;
    bus.wr_en = 1'b0;
    if (wr) begin m_data[wf] = wd; m_valid[wf] = 1; end
    chk("first_beat_valid", 32'(bus.rsp_valid), 32'd1);
    chk("busy_in_send", 32'(bus.busy), 32'd1);
  endtask

  task automatic run_until_idle(input bit rnd);
    int n = 0;
    bit wr;
    int wf;
    logic [11:0] wd;
    while ((bus.busy || sb.size() != 0) && n < 200) begin
      wr = 0; wf = 0; wd = '0;
      if (rnd) begin
        bus.rsp_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 3) == 0) begin
          wr = 1; wf = $urandom_range(0, ENTRIES - 1); wd = 12'($urandom);
          bus.wr_en = 1'b1; bus.wr_func = 4'(wf); bus.wr_data = wd;
        end
      end
      step();
      bus.wr_en = 1'b0;
      if (wr) begin m_data[wf] = wd; m_valid[wf] = 1; end
      n++;
    end
    bus.rsp_ready = 1'b1;
    chk("idle_within_budget", 32'(n < 200), 32'd1);
  endtask

  initial begin
    bus.wr_en = 0; bus.wr_func = '0; bus.wr_data = '0;
    bus.req_valid = 0; bus.req_func = '0; bus.req_pin = '0; bus.req_burst = 0;
    bus.rsp_ready = 1;
    model_clear();

    #2;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_wiring", 32'(bus.rsp_wiring), 32'd0);
    chk("rst_rsp_pin", 32'(bus.rsp_pin), 32'd0);
    chk("rst_rsp_last", 32'(bus.rsp_last), 32'd0);
    chk("rst_rsp_miss", 32'(bus.rsp_miss), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Single lookup, then back to idle after one beat.
    do_write(6, 12'o7654);
    issue(6, 2, 0, 0, 0, '0);
    chk("single_wiring", 32'(bus.rsp_wiring), 32'd6);
    step();
    chk("single_done_busy", 32'(bus.busy), 32'd0);
    chk("single_done_ready", 32'(bus.req_ready), 32'd1);
    run_until_idle(0);

    // Wrapping burst: pins 3,0,1,2 -> wiring 7,4,5,6.
    issue(6, 3, 1, 0, 0, '0);
    run_until_idle(0);

    // Never-written entry, single and burst.
    issue(9, 1, 0, 0, 0, '0);
    chk("miss_flag", 32'(bus.rsp_miss), 32'd1);
    run_until_idle(0);
    issue(9, 0, 1, 0, 0, '0);
    run_until_idle(0);

    // Backpressure on beat 2 plus a mid-burst overwrite of the same entry.
    issue(6, 3, 1, 0, 0, '0);
    step();
    bus.rsp_ready = 1'b0;
    bus.wr_en = 1'b1; bus.wr_func = 4'd6; bus.wr_data = 12'o0000;
    step();
    bus.wr_en = 1'b0;
    m_data[6] = 12'o0000; m_valid[6] = 1;
    step(); step();
    chk("stall_pin", 32'(bus.rsp_pin), 32'd0);
    chk("stall_wiring", 32'(bus.rsp_wiring), 32'd4);
    bus.rsp_ready = 1'b1;
    run_until_idle(0);
    issue(6, 1, 0, 0, 0, '0);
    run_until_idle(0);

    // Same-edge write and accept: old contents seen, new contents next time.
    do_write(6, 12'o7654);
    issue(6, 0, 0, 1, 6, 12'o1111);
    chk("rbw_old_wiring", 32'(bus.rsp_wiring), 32'd4);
    run_until_idle(0);
    issue(6, 0, 0, 0, 0, '0);
    chk("rbw_new_wiring", 32'(bus.rsp_wiring), 32'd1);
    run_until_idle(0);

    // Asynchronous reset in the middle of a burst.
    do_write(6, 12'o7654);
    issue(6, 3, 1, 0, 0, '0);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("arst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    sb.delete();
    model_clear();
    step();
    rst_n = 1'b1;
    step();
    issue(6, 0, 0, 0, 0, '0);
    chk("post_reset_miss", 32'(bus.rsp_miss), 32'd1);
    run_until_idle(0);

    // Randomised traffic with writes and backpressure.
    for (int i = 0; i < 60; i++) begin
      int f = $urandom_range(0, ENTRIES - 1);
      if ($urandom_range(0, 1) == 1)
        do_write($urandom_range(0, ENTRIES - 1), 12'($urandom));
      if ($urandom_range(0, 3) == 0)
        issue(f, $urandom_range(0, PINS - 1), 1'($urandom), 1, f, 12'($urandom));
      else
        issue(f, $urandom_range(0, PINS - 1), 1'($urandom), 0, 0, '0);
      run_until_idle(1);
      step();
    end

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
